arb_mux: RTL



---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux.sv | 16 +
 rtl/rr_arbiter.sv | 59 +++++
 rtl/arb_mux.sv | 110 +++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types for the arbitrated multiplexer: arbitration policy, burst-lock state and
// the index-width helper used by every module in the slice.
package mux_pkg;

   typedef enum logic {
      ARB_ROUND_ROBIN,
      ARB_FIXED
   } arb_mode_t;

   typedef enum logic {
      UNLOCKED,
      LOCKED
   } lock_state_t;

   // Width of a channel index; a single channel still needs one bit to carry it.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux.sv
// Plain N-to-1 data selector, indexed by an encoded channel number.
module mux
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned INPUT_BUS_COUNT = 4,
   localparam int unsigned IW             = idx_width(INPUT_BUS_COUNT)
) (
   input  logic [INPUT_BUS_COUNT-1:0][WIDTH-1:0] input_busses,
   input  logic [IW-1:0]                         sel,
   output logic [WIDTH-1:0]                      selected
);

   assign selected = input_busses[sel];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin or fixed-priority search over the request vector,
// or a pass-through of the locked channel while a burst holds the grant.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int unsigned COUNT = 4,
   localparam int unsigned IW   = idx_width(COUNT)
) (
   input  logic [COUNT-1:0] req,
   input  logic [IW-1:0]    pointer,
   input  arb_mode_t        mode,
   input  logic             lock_en,
   input  logic [IW-1:0]    lock_ch,
   output logic [COUNT-1:0] grant,
   output logic [IW-1:0]    grant_idx,
   output logic             grant_valid
);

   int unsigned   cand;
   logic [IW-1:0] cidx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      cidx        = '0;
      if (lock_en) begin
         if (req[lock_ch]) begin
            grant_valid = 1'b1;
            grant_idx   = lock_ch;
         end
      end else if (mode == ARB_FIXED) begin
         for (int i = int'(COUNT) - 1; i >= 0; i--) begin
            if (req[i]) begin
               grant_valid = 1'b1;
               grant_idx   = IW'(i);
            end
         end
      end else begin
         // Walk from the farthest candidate back to pointer+1 so the nearest one wins.
         for (int unsigned k = COUNT; k >= 1; k--) begin
            cand = 32'(pointer) + k;
            if (cand >= COUNT) begin
               cand = cand - COUNT;
            end
            cidx = IW'(cand);
            if (req[cidx]) begin
               grant_valid = 1'b1;
               grant_idx   = cidx;
            end
         end
      end
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/arb_mux.sv
// Registered, arbitrated N-to-1 multiplexer with valid/ready on every channel and an
// optional burst lock that pins the grant until the locked channel sends its last beat.
module arb_mux
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned INPUT_BUS_COUNT = 4,
   parameter arb_mode_t   ARB_MODE        = ARB_ROUND_ROBIN,
   parameter bit          BURST_LOCK      = 1'b1,
   localparam int unsigned IW             = idx_width(INPUT_BUS_COUNT)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [INPUT_BUS_COUNT-1:0]            in_valid,
   input  logic [INPUT_BUS_COUNT-1:0]            in_last,
   input  logic [INPUT_BUS_COUNT-1:0][WIDTH-1:0] input_busses,
   output logic [INPUT_BUS_COUNT-1:0]            in_ready,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [WIDTH-1:0]                      selected_data,
   output logic [IW-1:0]                         grant_index,
   output logic                                  out_last
);

   if (INPUT_BUS_COUNT < 2) begin : g_count_check
      $error("arb_mux: INPUT_BUS_COUNT must be at least 2");
   end

   logic [IW-1:0]              last_grant;
   lock_state_t                state;
   logic [IW-1:0]              lock_ch;
   logic                       lock_en;
   logic                       load;
   logic                       accept;
   logic [INPUT_BUS_COUNT-1:0] grant;
   logic [IW-1:0]              gidx;
   logic                       gvalid;
   logic [WIDTH-1:0]           mux_data;

   assign load     = !out_valid || out_ready;
   assign accept   = load && gvalid && !reset;
   assign in_ready = accept ? grant : '0;
   assign lock_en  = BURST_LOCK && (state == LOCKED);

   rr_arbiter #(
      .COUNT (INPUT_BUS_COUNT)
   ) u_arb (
      .req         (in_valid),
      .pointer     (last_grant),
      .mode        (ARB_MODE),
      .lock_en     (lock_en),
      .lock_ch     (lock_ch),
      .grant       (grant),
      .grant_idx   (gidx),
      .grant_valid (gvalid)
   );

   mux #(
      .WIDTH           (WIDTH),
      .INPUT_BUS_COUNT (INPUT_BUS_COUNT)
   ) u_mux (
      .input_busses (input_busses),
      .sel          (gidx),
      .selected     (mux_data)
   );

   // Pointer and lock move only with an accepted beat; a stalled cycle leaves them alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid     <= 1'b0;
         selected_data <= '0;
         grant_index   <= '0;
         out_last      <= 1'b0;
         last_grant    <= IW'(INPUT_BUS_COUNT - 1);
         state         <= UNLOCKED;
         lock_ch       <= '0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         selected_data <= mux_data;
         grant_index   <= gidx;
         out_last      <= in_last[gidx];
         last_grant    <= gidx;
         if (BURST_LOCK) begin
            case (state)
               UNLOCKED: begin
                  if (!in_last[gidx]) begin
                     state   <= LOCKED;
                     lock_ch <= gidx;
                  end
               end
               LOCKED: begin
                  if (in_last[gidx]) begin
                     state <= UNLOCKED;
                  end
               end
               default: state <= UNLOCKED;
            endcase
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (reset) $onehot0(in_ready));
   assert property (@(posedge clk) disable iff (reset)
      out_valid && !out_ready |=> out_valid && $stable(selected_data) && $stable(grant_index));
`endif

endmodule
